sva_stim_gen: RTL

Scripted stimulus generator for the sequence checkers under demo/fsm. It is the driving end of the checker interface.
- Derives the user clock gclk and user reset grst from sys_clk.
- Drives the a/b inputs in bursts of the form a[*N] ##1 b, as accepted from a command handshake.
- Emits the verdict the checker is expected to produce (exp_succ / exp_fail), so a bench can compare directly.
- Sits beside the checker in the bench and runs on the checker's sys_clk.

---
 rtl/sva_stim_pkg.sv | 35 +++
 rtl/sva_clk_div.sv | 39 +++
 rtl/sva_stim_gen.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sva_stim_pkg.sv
// Shared types for the checker stimulus generator.
//   stim_state_t : burst sequencer states
//   stim_cmd_t   : one registered burst command
//   VERDICT_*    : encoding of the expected checker verdict
//   burst_verdict: verdict a complete a[*N] ##1 b burst must produce
// STIM_LEN_W sets the command register and length-counter width; the top's
// LEN_W port width is expected to match it.
package sva_stim_pkg;

   localparam int STIM_LEN_W = 4;

   typedef enum logic [2:0] {
      S_RST   = 3'd0,
      S_IDLE  = 3'd1,
      S_A_RUN = 3'd2,
      S_B_PH  = 3'd3,
      S_GAP   = 3'd4
   } stim_state_t;

   typedef struct packed {
      logic [STIM_LEN_W-1:0] a_len;
      logic                  b_en;
      logic [STIM_LEN_W-1:0] gap;
   } stim_cmd_t;

   localparam logic [1:0] VERDICT_NONE = 2'b00;
   localparam logic [1:0] VERDICT_SUCC = 2'b01;
   localparam logic [1:0] VERDICT_FAIL = 2'b10;

   // The checked sequence needs at least one a followed by b.
   function automatic logic [1:0] burst_verdict(input logic a_seen, input logic b_en);
      return (a_seen && b_en) ? VERDICT_SUCC : VERDICT_FAIL;
   endfunction

endpackage

// File: rtl/sva_clk_div.sv
// Divides sys_clk down to the user clock gclk.
//   sys_clk  : system clock
//   sys_rst  : asynchronous active-high reset (gclk=0, counter=0)
//   gclk     : divided clock, period 2*CLK_DIV sys_clk cycles
//   rise_evt : one-cycle strobe, gclk goes high at the next edge
//   fall_evt : one-cycle strobe, gclk goes low at the next edge
module sva_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic sys_clk,
   input  logic sys_rst,
   output logic gclk,
   output logic rise_evt,
   output logic fall_evt
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] DIV_TC = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] div_cnt;
   logic             terminal;

   assign terminal = (div_cnt == DIV_TC);
   assign rise_evt = terminal & ~gclk;
   assign fall_evt = terminal & gclk;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         div_cnt <= '0;
         gclk    <= 1'b0;
      end else if (terminal) begin
         div_cnt <= '0;
         gclk    <= ~gclk;
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sva_stim_gen.sv
// Scripted stimulus generator driving a sequence checker with bursts of
// a[*N] ##1 b, plus the verdict the checker is expected to report.
//   sys_clk, sys_rst      : system clock, async active-high reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_a_len, cmd_b_en,
//   cmd_gap               : burst description (a periods, b enable, idle periods)
//   gclk, grst            : generated user clock and reset
//   a, b                  : stimulus, updated only on gclk falling edges
//   exp_succ, exp_fail    : one-cycle expected verdict pulses
//   busy                  : burst in progress
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RST   | grst held; count RST_GCLK gclk rises, release on a fall
// S_IDLE  | accept a command, start it on the next gclk fall
// S_A_RUN | a=1 for a_len gclk periods
// S_B_PH  | b=1 for one gclk period
// S_GAP   | a=b=0 for gap+1 gclk periods
module sva_stim_gen
   import sva_stim_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int RST_GCLK = 2,
   parameter int LEN_W    = STIM_LEN_W
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_a_len,
   input  logic             cmd_b_en,
   input  logic [LEN_W-1:0] cmd_gap,
   output logic             gclk,
   output logic             grst,
   output logic             a,
   output logic             b,
   output logic             exp_succ,
   output logic             exp_fail,
   output logic             busy
);

   localparam int RC_W = (RST_GCLK > 0) ? $clog2(RST_GCLK + 1) : 1;
   localparam logic [RC_W-1:0] RST_TC = RC_W'(RST_GCLK);

   logic                  rise_evt;
   logic                  fall_evt;
   stim_state_t           state_q;
   stim_state_t           state_nxt;
   stim_cmd_t             cmd_q;
   logic                  cmd_loaded_q;
   logic [STIM_LEN_W-1:0] cnt_q;
   logic [RC_W-1:0]       rst_cnt_q;
   logic                  pend_fail_q;
   logic                  a_nxt;
   logic                  b_nxt;
   logic                  grst_nxt;
   logic [1:0]            verdict_nxt;

   sva_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .gclk     (gclk),
      .rise_evt (rise_evt),
      .fall_evt (fall_evt)
   );

   assign cmd_ready = (state_q == S_IDLE) && !cmd_loaded_q;
   assign busy      = (state_q == S_A_RUN) || (state_q == S_B_PH) || (state_q == S_GAP);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= S_RST;
      else         state_q <= state_nxt;
   end

   // Every transition is qualified by fall_evt, so a/b/grst derived from
   // state_nxt only ever move on a gclk falling edge.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         S_RST:   if (fall_evt && rst_cnt_q == RST_TC) state_nxt = S_IDLE;
         S_IDLE: begin
            if (fall_evt && cmd_loaded_q) begin
               if (cmd_q.a_len != '0) state_nxt = S_A_RUN;
               else if (cmd_q.b_en)   state_nxt = S_B_PH;
               else                   state_nxt = S_GAP;
            end
         end
         S_A_RUN: if (fall_evt && cnt_q == STIM_LEN_W'(1))
                     state_nxt = cmd_q.b_en ? S_B_PH : S_GAP;
         S_B_PH:  if (fall_evt) state_nxt = S_GAP;
         S_GAP:   if (fall_evt && cnt_q == '0) state_nxt = S_IDLE;
         default: state_nxt = S_RST;
      endcase
   end

   always_comb begin
      a_nxt       = (state_nxt == S_A_RUN);
      b_nxt       = (state_nxt == S_B_PH);
      grst_nxt    = (state_nxt == S_RST);
      verdict_nxt = VERDICT_NONE;
      if (fall_evt) begin
         unique case (state_q)
            S_A_RUN: if (cnt_q == STIM_LEN_W'(1) && !cmd_q.b_en) verdict_nxt = VERDICT_FAIL;
            S_B_PH:  verdict_nxt = burst_verdict(cmd_q.a_len != '0, 1'b1);
            // a_len==0 with no b: the very first sampled period already lacks a.
            S_GAP:   if (pend_fail_q) verdict_nxt = VERDICT_FAIL;
            default: verdict_nxt = VERDICT_NONE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rst_cnt_q    <= '0;
         cmd_q        <= '0;
         cmd_loaded_q <= 1'b0;
         cnt_q        <= '0;
         pend_fail_q  <= 1'b0;
         a            <= 1'b0;
         b            <= 1'b0;
         grst         <= 1'b1;
         exp_succ     <= 1'b0;
         exp_fail     <= 1'b0;
      end else begin
         if (state_q == S_RST && rise_evt && rst_cnt_q != RST_TC)
            rst_cnt_q <= rst_cnt_q + RC_W'(1);

         if (cmd_valid && cmd_ready) begin
            cmd_q        <= '{a_len: STIM_LEN_W'(cmd_a_len), b_en: cmd_b_en,
                              gap: STIM_LEN_W'(cmd_gap)};
            cmd_loaded_q <= 1'b1;
         end else if (state_q == S_IDLE && state_nxt != S_IDLE) begin
            cmd_loaded_q <= 1'b0;
         end

         // One down-counter serves both the a run and the gap.
         if (state_nxt == S_A_RUN && state_q != S_A_RUN)
            cnt_q <= cmd_q.a_len;
         else if (state_nxt == S_GAP && state_q != S_GAP)
            cnt_q <= cmd_q.gap;
         else if (fall_evt && cnt_q != '0)
            cnt_q <= cnt_q - STIM_LEN_W'(1);

         if (state_q == S_IDLE && state_nxt == S_GAP)
            pend_fail_q <= 1'b1;
         else if (state_q == S_GAP && fall_evt)
            pend_fail_q <= 1'b0;

         a        <= a_nxt;
         b        <= b_nxt;
         grst     <= grst_nxt;
         exp_succ <= (verdict_nxt == VERDICT_SUCC);
         exp_fail <= (verdict_nxt == VERDICT_FAIL);
      end
   end

endmodule
